// File: rtl/ex_stage_pipe.sv
// ============================================================================
// Module   : ex_stage_pipe
// Purpose  : Handshaked execute stage. It contains the ALU, an iterative signed
//            divider, the {GT,ET} flags and branch resolution.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ex_stage_pipe #(
    parameter int XLEN  = 32,
    parameter int RF_AW = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_alu_op,
    input  logic [1:0]       in_br,
    input  logic             in_is_ret,
    input  logic             in_is_call,
    input  logic             in_is_ld,
    input  logic             in_is_st,
    input  logic             in_wb,
    input  logic [XLEN-1:0]  in_pc,
    input  logic [XLEN-1:0]  in_op1,
    input  logic [XLEN-1:0]  in_op2,
    input  logic [XLEN-1:0]  in_st_data,
    input  logic [26:0]      in_offset,
    input  logic [RF_AW-1:0] in_rd,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_result,
    output logic [XLEN-1:0]  out_st_data,
    output logic [RF_AW-1:0] out_rd,
    output logic             out_wb,
    output logic             out_is_ld,
    output logic             out_is_st,
    output logic             br_taken,
    output logic [XLEN-1:0]  br_target,
    output logic [1:0]       flags_q
);

    localparam int SHW = $clog2(XLEN);
    localparam int CW  = $clog2(XLEN + 1);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_DIV  = 1'b1;

    localparam logic [3:0] OP_ADD = 4'd0,  OP_SUB = 4'd1,  OP_CMP = 4'd2,  OP_MUL = 4'd3;
    localparam logic [3:0] OP_DIV = 4'd4,  OP_MOD = 4'd5,  OP_LSL = 4'd6,  OP_LSR = 4'd7;
    localparam logic [3:0] OP_ASR = 4'd8,  OP_OR  = 4'd9,  OP_AND = 4'd10, OP_NOT = 4'd11;
    localparam logic [3:0] OP_MOV = 4'd12;

    localparam logic [XLEN-1:0] C_FOUR     = XLEN'(4);
    localparam logic [CW-1:0]   C_CNT_LAST = CW'(XLEN);

    logic [0:0]       state_q, state_d;
    logic [CW-1:0]    cnt_q;
    logic [XLEN-1:0]  div_rem_q, div_quo_q, div_dsr_q;
    logic             p_mod_q, p_qneg_q, p_rneg_q, p_zero_q;
    logic [XLEN-1:0]  p_op1_q, p_st_data_q, p_target_q;
    logic [RF_AW-1:0] p_rd_q;
    logic             p_wb_q, p_ld_q, p_st_q, p_taken_q;

    logic             out_valid_q, out_wb_q, out_ld_q, out_st_q, br_taken_q;
    logic [XLEN-1:0]  out_result_q, out_st_data_q, br_target_q;
    logic [RF_AW-1:0] out_rd_q;
    logic [1:0]       flg_q;

    logic             w_out_free, w_accept, w_is_div, w_taken, w_div_done;
    logic             w_load_ex, w_load_div, w_ge;
    logic [XLEN-1:0]  w_result, w_target, w_off, w_a_mag, w_b_mag;
    logic [XLEN:0]    w_rem_sh;
    logic [XLEN-1:0]  w_q_sgn, w_r_sgn, w_div_res;
    logic [SHW-1:0]   w_sh;

    assign w_out_free = !out_valid_q || out_ready;
    assign w_accept   = in_valid && in_ready;
    assign w_is_div   = ((in_alu_op == OP_DIV) || (in_alu_op == OP_MOD)) && !in_is_call;
    assign w_div_done = (state_q == S_DIV) && (cnt_q == C_CNT_LAST);
    assign w_load_ex  = w_accept && !w_is_div;
    assign w_load_div = w_div_done && w_out_free;
    assign w_sh       = in_op2[SHW-1:0];

    // ---------------- FSM ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= S_IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (w_accept && w_is_div) state_d = S_DIV;
            S_DIV:   if (w_load_div)           state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready = 1'b0;
        case (state_q)
            S_IDLE:  in_ready = w_out_free;
            default: in_ready = 1'b0;
        endcase
    end

    // ---------------- ALU ----------------
    always_comb begin
        w_result = '0;
        case (in_alu_op)
            OP_ADD:  w_result = in_op1 + in_op2;
            OP_SUB:  w_result = in_op1 - in_op2;
            OP_MUL:  w_result = in_op1 * in_op2;
            OP_LSL:  w_result = in_op1 << w_sh;
            OP_LSR:  w_result = in_op1 >> w_sh;
            OP_ASR:  w_result = $signed(in_op1) >>> w_sh;
            OP_OR:   w_result = in_op1 | in_op2;
            OP_AND:  w_result = in_op1 & in_op2;
            OP_NOT:  w_result = ~in_op2;
            OP_MOV:  w_result = in_op2;
            default: w_result = '0;
        endcase
        if (in_is_call) w_result = in_pc + C_FOUR;
    end

    // Branch decision uses the flags as they stand before this edge
    assign w_off    = XLEN'($signed(in_offset)) << 2;
    assign w_taken  = (in_br == 2'd1) || ((in_br == 2'd2) && flg_q[0]) ||
                      ((in_br == 2'd3) && flg_q[1]) || in_is_ret;
    assign w_target = in_is_ret ? in_op1 : (in_pc + w_off);

    // ---------------- divider ----------------
    assign w_a_mag  = in_op1[XLEN-1] ? -in_op1 : in_op1;
    assign w_b_mag  = in_op2[XLEN-1] ? -in_op2 : in_op2;
    assign w_rem_sh = {div_rem_q, div_quo_q[XLEN-1]};
    assign w_ge     = w_rem_sh >= {1'b0, div_dsr_q};
    assign w_q_sgn  = p_qneg_q ? -div_quo_q : div_quo_q;
    assign w_r_sgn  = p_rneg_q ? -div_rem_q : div_rem_q;
    assign w_div_res = p_zero_q ? (p_mod_q ? p_op1_q : '1)
                                : (p_mod_q ? w_r_sgn : w_q_sgn);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q       <= '0;
            div_rem_q   <= '0;
            div_quo_q   <= '0;
            div_dsr_q   <= '0;
            p_mod_q     <= 1'b0;
            p_qneg_q    <= 1'b0;
            p_rneg_q    <= 1'b0;
            p_zero_q    <= 1'b0;
            p_op1_q     <= '0;
            p_st_data_q <= '0;
            p_target_q  <= '0;
            p_rd_q      <= '0;
            p_wb_q      <= 1'b0;
            p_ld_q      <= 1'b0;
            p_st_q      <= 1'b0;
            p_taken_q   <= 1'b0;
        end else if (w_accept && w_is_div) begin
            cnt_q       <= '0;
            div_rem_q   <= '0;
            div_quo_q   <= w_a_mag;
            div_dsr_q   <= w_b_mag;
            p_mod_q     <= (in_alu_op == OP_MOD);
            p_qneg_q    <= in_op1[XLEN-1] ^ in_op2[XLEN-1];
            p_rneg_q    <= in_op1[XLEN-1];
            p_zero_q    <= (in_op2 == '0);
            p_op1_q     <= in_op1;
            p_st_data_q <= in_st_data;
            p_target_q  <= w_target;
            p_rd_q      <= in_rd;
            p_wb_q      <= in_wb;
            p_ld_q      <= in_is_ld;
            p_st_q      <= in_is_st;
            p_taken_q   <= w_taken;
        end else if ((state_q == S_DIV) && (cnt_q != C_CNT_LAST)) begin
            cnt_q     <= cnt_q + 1'b1;
            div_rem_q <= w_ge ? (w_rem_sh[XLEN-1:0] - div_dsr_q) : w_rem_sh[XLEN-1:0];
            div_quo_q <= {div_quo_q[XLEN-2:0], w_ge};
        end
    end

    // ---------------- output register and flags ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid_q   <= 1'b0;
            out_result_q  <= '0;
            out_st_data_q <= '0;
            out_rd_q      <= '0;
            out_wb_q      <= 1'b0;
            out_ld_q      <= 1'b0;
            out_st_q      <= 1'b0;
            br_taken_q    <= 1'b0;
            br_target_q   <= '0;
            flg_q         <= 2'b00;
        end else begin
            out_valid_q <= w_load_ex || w_load_div || (out_valid_q && !out_ready);
            br_taken_q  <= 1'b0;
            if (w_load_ex) begin
                out_result_q  <= w_result;
                out_st_data_q <= in_st_data;
                out_rd_q      <= in_rd;
                out_wb_q      <= in_wb;
                out_ld_q      <= in_is_ld;
                out_st_q      <= in_is_st;
                br_taken_q    <= w_taken;
                br_target_q   <= w_target;
            end else if (w_load_div) begin
                out_result_q  <= w_div_res;
                out_st_data_q <= p_st_data_q;
                out_rd_q      <= p_rd_q;
                out_wb_q      <= p_wb_q;
                out_ld_q      <= p_ld_q;
                out_st_q      <= p_st_q;
                br_taken_q    <= p_taken_q;
                br_target_q   <= p_target_q;
            end
            if (w_accept && (in_alu_op == OP_CMP))
                flg_q <= {($signed(in_op1) > $signed(in_op2)), (in_op1 == in_op2)};
        end
    end

    assign out_valid   = out_valid_q;
    assign out_result  = out_result_q;
    assign out_st_data = out_st_data_q;
    assign out_rd      = out_rd_q;
    assign out_wb      = out_wb_q;
    assign out_is_ld   = out_ld_q;
    assign out_is_st   = out_st_q;
    assign br_taken    = br_taken_q;
    assign br_target   = br_target_q;
    assign flags_q     = flg_q;

endmodule

`default_nettype wire

// File: tb/tb_ex_stage_pipe.sv
// ============================================================================
// Module   : tb_ex_stage_pipe
// Purpose  : Directed vector bench for ex_stage_pipe (XLEN=32).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ex_stage_pipe;

    localparam int XLEN  = 32;
    localparam int RF_AW = 4;

    logic             clk, rst;
    logic             in_valid, in_ready;
    logic [3:0]       in_alu_op;
    logic [1:0]       in_br;
    logic             in_is_ret, in_is_call, in_is_ld, in_is_st, in_wb;
    logic [XLEN-1:0]  in_pc, in_op1, in_op2, in_st_data;
    logic [26:0]      in_offset;
    logic [RF_AW-1:0] in_rd;
    logic             out_valid, out_ready;
    logic [XLEN-1:0]  out_result, out_st_data;
    logic [RF_AW-1:0] out_rd;
    logic             out_wb, out_is_ld, out_is_st;
    logic             br_taken;
    logic [XLEN-1:0]  br_target;
    logic [1:0]       flags_q;

    int n_cmp;
    int n_err;

    ex_stage_pipe #(.XLEN(XLEN), .RF_AW(RF_AW)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_alu_op(in_alu_op), .in_br(in_br),
        .in_is_ret(in_is_ret), .in_is_call(in_is_call),
        .in_is_ld(in_is_ld), .in_is_st(in_is_st), .in_wb(in_wb),
        .in_pc(in_pc), .in_op1(in_op1), .in_op2(in_op2),
        .in_st_data(in_st_data), .in_offset(in_offset), .in_rd(in_rd),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_st_data(out_st_data), .out_rd(out_rd),
        .out_wb(out_wb), .out_is_ld(out_is_ld), .out_is_st(out_is_st),
        .br_taken(br_taken), .br_target(br_target), .flags_q(flags_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a, b, pc;
        logic [1:0]  br;
        logic        call, ret;
        logic [26:0] off;
        logic [31:0] exp_res;
        logic        exp_tk;
        logic [31:0] exp_tgt;
        logic [1:0]  exp_fl;
    } vec_t;

    vec_t tbl[20];

    function automatic vec_t mk(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                input logic [31:0] pc, input logic [1:0] br, input logic ret,
                                input logic [26:0] off, input logic [31:0] er, input logic et,
                                input logic [31:0] eg, input logic [1:0] ef);
        vec_t v;
        v.op = op; v.a = a; v.b = b; v.pc = pc; v.br = br; v.call = 1'b0; v.ret = ret;
        v.off = off; v.exp_res = er; v.exp_tk = et; v.exp_tgt = eg; v.exp_fl = ef;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] pc, input logic [1:0] br, input logic call,
                         input logic ret, input logic [26:0] off, input logic [3:0] rd);
        in_valid = 1'b1; in_alu_op = op; in_op1 = a; in_op2 = b; in_pc = pc; in_br = br;
        in_is_call = call; in_is_ret = ret; in_offset = off; in_rd = rd;
        in_wb = 1'b1; in_is_ld = 1'b0; in_is_st = 1'b0; in_st_data = 32'hA5A5_0000 | {28'd0, rd};
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Accept at edge 0; XLEN+1 samples with nothing visible, result after edge XLEN+1
    task automatic run_div(input string name, input logic [3:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] exp, input logic [1:0] fl);
        int early;
        int rdy;
        early = 0; rdy = 0;
        drive(op, a, b, 32'h0, 2'd0, 1'b0, 1'b0, 27'd0, 4'd7);
        tick();
        in_valid = 1'b0;
        for (int k = 0; k <= XLEN; k++) begin
            if (k > 0) tick();
            if (out_valid) early++;
            if (in_ready) rdy++;
        end
        tick();
        chk({name, " early out_valid count"}, early, 0);
        chk({name, " in_ready during div"}, rdy, 0);
        chk({name, " out_valid at edge XLEN+1"}, out_valid, 1);
        chk({name, " result"}, out_result, exp);
        chk({name, " rd"}, out_rd, 4'd7);
        chk({name, " flags"}, flags_q, fl);
    endtask

    initial begin
        n_cmp = 0; n_err = 0;
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        in_alu_op = '0; in_br = '0; in_is_ret = 0; in_is_call = 0; in_is_ld = 0;
        in_is_st = 0; in_wb = 0; in_pc = '0; in_op1 = '0; in_op2 = '0;
        in_st_data = '0; in_offset = '0; in_rd = '0;

        //            op     a             b             pc        br   ret off          res           tk  tgt           fl
        tbl[0]  = mk(4'd0,  32'hFFFFFFFF, 32'd1,        32'h0,    2'd0, 0, 27'd0,       32'h0,        0, 32'h0,        2'b00);
        tbl[1]  = mk(4'd1,  32'd3,        32'd5,        32'h0,    2'd0, 0, 27'd0,       32'hFFFFFFFE, 0, 32'h0,        2'b00);
        tbl[2]  = mk(4'd2,  32'hFFFFFFFE, 32'd1,        32'h0,    2'd0, 0, 27'd0,       32'h0,        0, 32'h0,        2'b00);
        tbl[3]  = mk(4'd12, 32'd0,        32'd0,        32'h100,  2'd3, 0, 27'd4,       32'h0,        0, 32'h0,        2'b00);
        tbl[4]  = mk(4'd2,  32'd5,        32'd5,        32'h0,    2'd0, 0, 27'd0,       32'h0,        0, 32'h0,        2'b01);
        tbl[5]  = mk(4'd12, 32'd0,        32'd0,        32'h100,  2'd2, 0, 27'd4,       32'h0,        1, 32'h110,      2'b01);
        tbl[6]  = mk(4'd6,  32'd1,        32'h21,       32'h0,    2'd0, 0, 27'd0,       32'd2,        0, 32'h0,        2'b01);
        tbl[7]  = mk(4'd7,  32'h80000000, 32'd4,        32'h0,    2'd0, 0, 27'd0,       32'h08000000, 0, 32'h0,        2'b01);
        tbl[8]  = mk(4'd8,  32'h80000000, 32'd4,        32'h0,    2'd0, 0, 27'd0,       32'hF8000000, 0, 32'h0,        2'b01);
        tbl[9]  = mk(4'd9,  32'hF0,       32'h0F,       32'h0,    2'd0, 0, 27'd0,       32'hFF,       0, 32'h0,        2'b01);
        tbl[10] = mk(4'd10, 32'hFF,       32'h3C,       32'h0,    2'd0, 0, 27'd0,       32'h3C,       0, 32'h0,        2'b01);
        tbl[11] = mk(4'd11, 32'd0,        32'd0,        32'h0,    2'd0, 0, 27'd0,       32'hFFFFFFFF, 0, 32'h0,        2'b01);
        tbl[12] = mk(4'd12, 32'd0,        32'h1234,     32'h0,    2'd0, 0, 27'd0,       32'h1234,     0, 32'h0,        2'b01);
        tbl[13] = mk(4'd13, 32'd5,        32'd6,        32'h0,    2'd0, 0, 27'd0,       32'h0,        0, 32'h0,        2'b01);
        tbl[14] = mk(4'd2,  32'd7,        32'hFFFFFFFF, 32'h0,    2'd0, 0, 27'd0,       32'h0,        0, 32'h0,        2'b10);
        tbl[15] = mk(4'd12, 32'd0,        32'd0,        32'h200,  2'd3, 0, 27'h7FFFFFF, 32'h0,        1, 32'h1FC,      2'b10);
        tbl[16] = mk(4'd3,  32'd3,        32'hFFFFFFFF, 32'h0,    2'd0, 0, 27'd0,       32'hFFFFFFFD, 0, 32'h0,        2'b10);
        tbl[17] = mk(4'd0,  32'd1,        32'd1,        32'h300,  2'd1, 0, 27'd2,       32'd2,        1, 32'h308,      2'b10);
        tbl[18] = mk(4'd12, 32'h500,      32'd9,        32'h0,    2'd0, 1, 27'd0,       32'd9,        1, 32'h500,      2'b10);
        tbl[19] = mk(4'd12, 32'd0,        32'd0,        32'h0,    2'd2, 0, 27'd4,       32'h0,        0, 32'h0,        2'b10);

        // Reset state
        repeat (3) tick();
        chk("reset out_valid", out_valid, 0);
        chk("reset out_result", out_result, 0);
        chk("reset flags", flags_q, 0);
        chk("reset br_taken", br_taken, 0);
        chk("reset br_target", br_target, 0);
        chk("reset in_ready", in_ready, 1);
        @(negedge clk); rst = 1'b1;
        tick();

        // Back-to-back single-cycle table
        for (int i = 0; i < 20; i++) begin
            drive(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].pc, tbl[i].br, tbl[i].call,
                  tbl[i].ret, tbl[i].off, i[3:0]);
            chk($sformatf("v%0d in_ready", i), in_ready, 1);
            tick();
            chk($sformatf("v%0d out_valid", i), out_valid, 1);
            chk($sformatf("v%0d result", i), out_result, tbl[i].exp_res);
            chk($sformatf("v%0d br_taken", i), br_taken, tbl[i].exp_tk);
            if (tbl[i].exp_tk) chk($sformatf("v%0d br_target", i), br_target, tbl[i].exp_tgt);
            chk($sformatf("v%0d flags", i), flags_q, tbl[i].exp_fl);
            chk($sformatf("v%0d rd", i), out_rd, i[3:0]);
        end

        // Divider, flags stay at 2'b10 from the last CMP
        run_div("div -7/2", 4'd4, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 2'b10);
        run_div("mod -7/2", 4'd5, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 2'b10);
        run_div("div 9/0",  4'd4, 32'd9,        32'd0, 32'hFFFFFFFF, 2'b10);
        run_div("mod 9/0",  4'd5, 32'd9,        32'd0, 32'd9,        2'b10);
        run_div("div 100/-7", 4'd4, 32'd100,    32'hFFFFFFF9, 32'hFFFFFFF2, 2'b10);
        run_div("mod 100/-7", 4'd5, 32'd100,    32'hFFFFFFF9, 32'd2,        2'b10);

        // Stall: MUL result held while MA is not ready
        in_valid = 1'b0;
        tick();
        out_ready = 1'b0;
        drive(4'd3, 32'h10000, 32'h10000, 32'h0, 2'd0, 1'b0, 1'b0, 27'd0, 4'd3);
        tick();
        chk("stall mul valid", out_valid, 1);
        drive(4'd0, 32'd1, 32'd1, 32'h0, 2'd0, 1'b0, 1'b0, 27'd0, 4'd4);
        begin
            int moved;
            moved = 0;
            for (int k = 0; k < 5; k++) begin
                if (in_ready || !out_valid || out_result != 32'h0 || out_rd != 4'd3) moved++;
                tick();
            end
            chk("stall stable cycles", moved, 0);
        end
        out_ready = 1'b1;
        #1;
        chk("stall release in_ready", in_ready, 1);
        tick();
        chk("after stall result", out_result, 32'd2);
        chk("after stall rd", out_rd, 4'd4);

        // Reset mid-division
        drive(4'd4, 32'd100, 32'd7, 32'h0, 2'd0, 1'b0, 1'b0, 27'd0, 4'd1);
        tick();
        in_valid = 1'b0;
        repeat (10) tick();
        rst = 1'b0;
        #1;
        chk("rst-div out_valid", out_valid, 0);
        chk("rst-div flags", flags_q, 0);
        @(negedge clk); rst = 1'b1;
        tick();
        chk("rst-div in_ready", in_ready, 1);
        begin
            int seen;
            seen = 0;
            for (int k = 0; k < XLEN + 4; k++) begin
                if (out_valid) seen++;
                tick();
            end
            chk("rst-div no partial result", seen, 0);
        end

        // CALL
        drive(4'd0, 32'd0, 32'd0, 32'h40, 2'd1, 1'b1, 1'b0, 27'd8, 4'd15);
        tick();
        in_valid = 1'b0;
        chk("call result", out_result, 32'h44);
        chk("call br_taken", br_taken, 1);
        chk("call br_target", br_target, 32'h60);
        tick();
        chk("call pulse ends", br_taken, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
